// File: rtl/mips_io_pkg.sv
// Shared definitions for the memory-mapped I/O ports hanging off the MIPS data bus.
//   txState_t     : UART transmit FSM states
//   *_OFF         : register offsets within the 8-byte window (Address[2:0])
//   STATUS_*      : bit positions inside the STATUS word
package mips_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    localparam logic [2:0] TXDATA_OFF = 3'h0;
    localparam logic [2:0] STATUS_OFF = 3'h4;

    localparam int unsigned STATUS_FULL_BIT  = 0;
    localparam int unsigned STATUS_EMPTY_BIT = 1;
    localparam int unsigned STATUS_BUSY_BIT  = 2;
    localparam int unsigned STATUS_OVF_BIT   = 3;
    localparam int unsigned STATUS_CNT_LSB   = 4;  // count occupies [7:4]

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with show-ahead output.
//   clk, reset : clock and synchronous active-high reset
//   push, din  : write strobe and data; ignored when full unless a pop frees a slot
//   pop, dout  : read strobe and current head (valid whenever !empty)
//   full, empty, count : occupancy flags and entry count
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wrPtr;
    logic [PtrW-1:0]  rdPtr;
    logic             doPush;
    logic             doPop;

    assign full  = (count == FullCount);
    assign empty = (count == '0);
    assign dout  = mem[rdPtr];

    assign doPop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign doPush = push && (!full || doPop);

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;  // power-of-two depth wraps naturally
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (doPush && !doPop) begin
                count <= count + 1'b1;
            end else if (doPop && !doPush) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_uart_tx_port.sv
// Memory-mapped UART transmitter on the MIPS data bus (8N1, LSB first).
//   clk, reset          : clock and synchronous active-high reset
//   MemWrite, MemRead   : store / load strobes from the control unit
//   Address, WriteData  : byte address and store data ([7:0] is the TX byte)
//   ReadData            : combinational STATUS word on a load from offset 4, else 0
//   Hit                 : combinational window decode of Address[31:3]
//   tx                  : registered serial output, idle high
module mips_uart_tx_port
    import mips_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0020,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        tx
);

    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    logic [2:0]      offset;
    logic            dataWrite;
    logic            statusWrite;
    logic            fifoPop;
    logic [7:0]      fifoDout;
    logic            fifoFull;
    logic            fifoEmpty;
    logic [CntW-1:0] fifoCount;
    logic [7:0]      countField;
    logic [31:0]     statusWord;

    txState_t        stateQ, stateD;
    logic [BaudW-1:0] baudQ, baudD;
    logic [2:0]      bitIdxQ, bitIdxD;
    logic [7:0]      shiftQ, shiftD;
    logic            txQ, txD;
    logic            overflowQ, overflowD;

    logic            unusedWriteData;
    assign unusedWriteData = ^{WriteData[31:8]};

    assign offset      = Address[2:0];
    assign Hit         = (Address[31:3] == BASE_ADDR[31:3]);
    assign dataWrite   = MemWrite && Hit && (offset == TXDATA_OFF);
    assign statusWrite = MemWrite && Hit && (offset == STATUS_OFF);
    assign tx          = txQ;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) txFifo (
        .clk   (clk),
        .reset (reset),
        .push  (dataWrite),
        .pop   (fifoPop),
        .din   (WriteData[7:0]),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (fifoCount)
    );

    // Count field is 4 bits wide; zero-extend first so any depth fits the slice.
    assign countField = 8'(fifoCount);

    always_comb begin
        statusWord = '0;
        statusWord[STATUS_FULL_BIT]              = fifoFull;
        statusWord[STATUS_EMPTY_BIT]             = fifoEmpty;
        statusWord[STATUS_BUSY_BIT]              = (stateQ != IDLE);
        statusWord[STATUS_OVF_BIT]               = overflowQ;
        statusWord[STATUS_CNT_LSB +: 4]          = countField[3:0];
    end

    assign ReadData = (Hit && MemRead && (offset == STATUS_OFF)) ? statusWord : 32'h0;

    always_comb begin
        overflowD = overflowQ;
        if (statusWrite && WriteData[3]) begin
            overflowD = 1'b0;
        end
        // Dropped push: full and no slot freed this cycle.
        if (dataWrite && fifoFull && !fifoPop) begin
            overflowD = 1'b1;
        end
    end

    always_comb begin
        stateD  = stateQ;
        baudD   = baudQ;
        bitIdxD = bitIdxQ;
        shiftD  = shiftQ;
        fifoPop = 1'b0;
        unique case (stateQ)
            IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    shiftD  = fifoDout;
                    baudD   = '0;
                    stateD  = START;
                end
            end
            START: begin
                if (baudQ == BaudLast) begin
                    baudD   = '0;
                    bitIdxD = 3'd0;
                    stateD  = DATA;
                end else begin
                    baudD = baudQ + 1'b1;
                end
            end
            DATA: begin
                if (baudQ == BaudLast) begin
                    baudD  = '0;
                    shiftD = shiftQ >> 1;
                    if (bitIdxQ == 3'd7) begin
                        stateD = STOP;
                    end else begin
                        bitIdxD = bitIdxQ + 1'b1;
                    end
                end else begin
                    baudD = baudQ + 1'b1;
                end
            end
            STOP: begin
                if (baudQ == BaudLast) begin
                    baudD  = '0;
                    stateD = IDLE;
                end else begin
                    baudD = baudQ + 1'b1;
                end
            end
            default: stateD = IDLE;
        endcase

        // tx is derived from the next state so the line register changes with the FSM.
        unique case (stateD)
            START:   txD = 1'b0;
            DATA:    txD = shiftD[0];
            default: txD = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ    <= IDLE;
            baudQ     <= '0;
            bitIdxQ   <= '0;
            shiftQ    <= '0;
            txQ       <= 1'b1;
            overflowQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            baudQ     <= baudD;
            bitIdxQ   <= bitIdxD;
            shiftQ    <= shiftD;
            txQ       <= txD;
            overflowQ <= overflowD;
        end
    end

endmodule
